apb_param_slave: RTL and testbench
==================================

APB_PARAM_SLAVE -- requirements
Module: apb_param_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: PADDR width in bits, byte address.
REQ-002 SHALL have parameter DATA_W, default 32: PWDATA/PRDATA width; legal values 8, 16, 32.
REQ-003 SHALL have parameter DEPTH, default 64: number of DATA_W-bit words of storage.
REQ-004 SHALL have parameter WAIT_CYC, default 0: wait states inserted per transfer; legal range 0-15.
REQ-005 SHALL have port PCLK, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port PRESETn, input, 1 bit: reset, asynchronous assert, active-low.
REQ-007 SHALL have port PSEL, input, 1 bit: slave select.
REQ-008 SHALL have port PENABLE, input, 1 bit: access phase.
REQ-009 SHALL have port PWRITE, input, 1 bit: 1 = write, 0 = read.
REQ-010 SHALL have port PADDR, input, ADDR_W bits: byte address.
REQ-011 SHALL have port PWDATA, input, DATA_W bits: write data.
REQ-012 SHALL have port PSTRB, input, DATA_W/8 bits: byte-lane write enables.
REQ-013 SHALL have port PRDATA, output, DATA_W bits: read data.
REQ-014 SHALL have port PREADY, output, 1 bit: transfer completion.
REQ-015 SHALL have port PSLVERR, output, 1 bit: error response, valid only while PREADY=1.

Function
REQ-016 SHALL implement FSM states IDLE and ACCESS, plus a 4-bit wait counter.
REQ-017 In IDLE, PSEL=1 and PENABLE=0 SHALL latch PADDR, PWRITE, PWDATA and PSTRB, load the counter with WAIT_CYC, and go to ACCESS.
REQ-018 In IDLE, PSEL=1 and PENABLE=1 with no prior setup cycle SHALL be ignored: state stays IDLE, no write, PREADY=0.
REQ-019 In ACCESS, counter≠0 SHALL decrement the counter and hold PREADY=0.
REQ-020 In ACCESS, counter=0 SHALL drive PREADY=1 (Moore, from state and counter) and return to IDLE next cycle.
REQ-021 A transfer SHALL therefore complete WAIT_CYC+1 cycles after the setup cycle.
REQ-022 In ACCESS, PSEL=0 or PENABLE=0 SHALL abort the transfer: return to IDLE, no write, no PREADY pulse.
REQ-023 Word index SHALL equal latched PADDR >> log2(DATA_W/8).
REQ-024 Index ≥ DEPTH or nonzero low (misaligned) address bits SHALL give PSLVERR=1 in the completion cycle, suppress the write, and return PRDATA=0.
REQ-025 A write SHALL commit only on the completion cycle, and only to byte lanes with PSTRB bit = 1; other lanes are unchanged.
REQ-026 A read SHALL present the word on PRDATA during the completion cycle; PRDATA SHALL be 0 in all other cycles.
REQ-027 PSTRB SHALL be ignored on reads.
REQ-028 A setup cycle arriving in the cycle after completion SHALL be accepted with no dead cycle (back-to-back).
REQ-029 A read of an address written in the immediately preceding transfer SHALL return the new data.
REQ-030 PSLVERR SHALL be 0 whenever PREADY=0.

Reset
REQ-031 PRESETn=0 SHALL asynchronously force the state to IDLE, the counter to 0, PREADY=0, PSLVERR=0, PRDATA=0, and all storage words to 0.
REQ-032 Reset asserted mid-transfer SHALL discard that transfer with no partial write.
REQ-033 The first transfer SHALL be accepted on the first setup cycle after PRESETn deasserts.

Structure
REQ-034 Shared package apb_slave_pkg SHALL hold the FSM state enum, the default parameter constants and the PSLVERR code meaning.
REQ-035 Storage SHALL be a sub-module apb_mem_array: DEPTH×DATA_W, byte-strobed synchronous write, combinational read, async clear.
REQ-036 The FSM, wait counter and decode SHALL live in apb_param_slave.

Verification
REQ-037 WAIT_CYC=0: write 0xDEADBEEF to 0x10, then read 0x10 back-to-back -> PREADY high one cycle after each setup, PRDATA=0xDEADBEEF, PSLVERR=0.
REQ-038 WAIT_CYC=3: read 0x04 -> PREADY low for 3 ACCESS cycles, high on the 4th, PRDATA=0 (post-reset value).
REQ-039 Write 0x11223344 to 0x08, then write 0xAABBCCDD with PSTRB=4'b0101 -> read 0x08 returns 0x11BB33DD.
REQ-040 Address 0x100 (index ≥ 64) or 0x02 (misaligned) -> PSLVERR=1 with PREADY, PRDATA=0, memory unchanged.
REQ-041 PSEL dropped in the 2nd ACCESS cycle (WAIT_CYC=3) of a write -> no PREADY, and a later read shows old data.
REQ-042 PRESETn pulsed low mid-ACCESS -> outputs 0 immediately, and a later read of a previously written address returns 0.

Source files
------------

// File: rtl/apb_slave_pkg.sv
// Shared definitions for the parameterised APB slave: FSM states, default
// parameter values and the PSLVERR response encoding.
package apb_slave_pkg;

    localparam int unsigned DEF_ADDR_W   = 8;
    localparam int unsigned DEF_DATA_W   = 32;
    localparam int unsigned DEF_DEPTH    = 64;
    localparam int unsigned DEF_WAIT_CYC = 0;
    localparam int unsigned CNT_W        = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } apb_state_e;

    // PSLVERR meaning while PREADY is high
    localparam logic SLVERR_OKAY  = 1'b0;
    localparam logic SLVERR_ERROR = 1'b1;

endpackage

// File: rtl/apb_mem_array.sv
// DEPTH x DATA_W word storage with byte-strobed synchronous write,
// combinational read and asynchronous clear of every word.
module apb_mem_array #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned IDX_W  = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [IDX_W-1:0]    idx,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] strb,
    output logic [DATA_W-1:0]   rdata_c
);

    localparam int unsigned NB = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < int'(NB); b++) begin
                if (strb[b]) begin
                    mem_q[idx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    // Guard keeps non power-of-two depths from reading past the array
    assign rdata_c = (32'(idx) < DEPTH) ? mem_q[idx] : '0;

endmodule

// File: rtl/apb_param_slave.sv
// APB slave with parameterised width, depth and wait states: setup/access
// FSM, wait counter, address decode and registered completion outputs.
module apb_param_slave
    import apb_slave_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned WAIT_CYC = DEF_WAIT_CYC
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic                PSEL,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [ADDR_W-1:0]   PADDR,
    input  logic [DATA_W-1:0]   PWDATA,
    input  logic [DATA_W/8-1:0] PSTRB,
    output logic [DATA_W-1:0]   PRDATA,
    output logic                PREADY,
    output logic                PSLVERR
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned LSB   = $clog2(NB);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0]  WAIT_LD  = CNT_W'(WAIT_CYC);
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((64'(1) << LSB) - 64'(1));

    apb_state_e          state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                write_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [NB-1:0]       strb_q;
    logic                pready_q;
    logic                pslverr_q;
    logic [DATA_W-1:0]   prdata_q;

    logic                setup_c;
    logic                access_c;
    logic                finish_c;
    logic                commit_c;
    logic [ADDR_W-1:0]   src_addr_c;
    logic                src_write_c;
    logic [ADDR_W-1:0]   src_word_c;
    logic                src_err_c;
    logic [IDX_W-1:0]    src_idx_c;
    logic [DATA_W-1:0]   rd_data_c;

    assign setup_c  = (state_q == ST_IDLE) && PSEL && !PENABLE;
    assign access_c = PSEL && PENABLE;

    // True on the edge that enters the completion cycle
    assign finish_c = (setup_c && (WAIT_CYC == 0)) ||
                      ((state_q == ST_ACCESS) && (cnt_q == CNT_W'(1)) && access_c);

    // Decode the live bus in IDLE, the latched request once in ACCESS
    assign src_addr_c  = (state_q == ST_IDLE) ? PADDR  : addr_q;
    assign src_write_c = (state_q == ST_IDLE) ? PWRITE : write_q;
    assign src_word_c  = src_addr_c >> LSB;
    assign src_err_c   = (|(src_addr_c & LOW_MASK)) || (32'(src_word_c) >= DEPTH);
    assign src_idx_c   = IDX_W'(src_word_c);

    // Write lands at the end of the completion cycle, never on error or abort
    assign commit_c = pready_q && write_q && (pslverr_q == SLVERR_OKAY) && access_c;

    apb_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem (
        .clk     (PCLK),
        .rst_n   (PRESETn),
        .we      (commit_c),
        .idx     (src_idx_c),
        .wdata   (wdata_q),
        .strb    (strb_q),
        .rdata_c (rd_data_c)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= SLVERR_OKAY;
            prdata_q  <= '0;
        end else begin
            pready_q  <= finish_c;
            pslverr_q <= (finish_c && src_err_c) ? SLVERR_ERROR : SLVERR_OKAY;
            prdata_q  <= (finish_c && !src_write_c && !src_err_c) ? rd_data_c : '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (setup_c) begin
                        state_q <= ST_ACCESS;
                        cnt_q   <= WAIT_LD;
                        addr_q  <= PADDR;
                        write_q <= PWRITE;
                        wdata_q <= PWDATA;
                        strb_q  <= PSTRB;
                    end
                end
                ST_ACCESS: begin
                    if ((cnt_q == '0) || !access_c) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;
    assign PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb_param_slave.sv
// Scoreboard bench for apb_param_slave: a zero-wait instance with a wide
// address bus and a three-wait instance share one APB master.
module tb_apb_param_slave;

    logic        clk;
    logic        rst_n;
    logic        psel0;
    logic        psel3;
    logic        penable;
    logic        pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata0;
    logic [31:0] prdata3;
    logic        pready0;
    logic        pready3;
    logic        pslverr0;
    logic        pslverr3;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb_q[$];

    apb_param_slave #(
        .ADDR_W   (12),
        .DATA_W   (32),
        .DEPTH    (64),
        .WAIT_CYC (0)
    ) dut0 (
        .PCLK    (clk),
        .PRESETn (rst_n),
        .PSEL    (psel0),
        .PENABLE (penable),
        .PWRITE  (pwrite),
        .PADDR   (paddr),
        .PWDATA  (pwdata),
        .PSTRB   (pstrb),
        .PRDATA  (prdata0),
        .PREADY  (pready0),
        .PSLVERR (pslverr0)
    );

    apb_param_slave #(
        .ADDR_W   (8),
        .DATA_W   (32),
        .DEPTH    (64),
        .WAIT_CYC (3)
    ) dut3 (
        .PCLK    (clk),
        .PRESETn (rst_n),
        .PSEL    (psel3),
        .PENABLE (penable),
        .PWRITE  (pwrite),
        .PADDR   (paddr[7:0]),
        .PWDATA  (pwdata),
        .PSTRB   (pstrb),
        .PRDATA  (prdata3),
        .PREADY  (pready3),
        .PSLVERR (pslverr3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One full transfer on the selected instance; expectation queued at drive time
    task automatic apb_xfer(input int sel, input logic wr, input logic [11:0] a,
                            input logic [31:0] wd, input logic [3:0] st,
                            input logic [31:0] exp_d, input logic exp_e, input string tag);
        exp_t        e;
        logic        rdy;
        logic        err;
        logic [31:0] rd;
        int          cyc;
        bit          done;
        sb_q.push_back('{exp_d, exp_e, (sel == 3) ? 4 : 1});
        @(negedge clk);
        psel0   = (sel == 0);
        psel3   = (sel == 3);
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = wd;
        pstrb   = st;
        done    = 1'b0;
        cyc     = 0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
            penable = 1'b1;
            rdy = (sel == 3) ? pready3  : pready0;
            err = (sel == 3) ? pslverr3 : pslverr0;
            rd  = (sel == 3) ? prdata3  : prdata0;
            if (rdy) begin
                e = sb_q.pop_front();
                check({tag, "_rdata"}, rd, e.data);
                check({tag, "_slverr"}, 32'(err), 32'(e.err));
                check({tag, "_latency"}, 32'(cyc), 32'(e.lat));
                done = 1'b1;
            end else begin
                check({tag, "_wait_rdata"}, rd, 32'h0);
                check({tag, "_wait_slverr"}, 32'(err), 32'h0);
            end
        end
        if (!done) begin
            e = sb_q.pop_front();
            check({tag, "_timeout"}, 32'(cyc), 32'(e.lat));
        end
    endtask

    task automatic bus_idle();
        @(negedge clk);
        psel0   = 1'b0;
        psel3   = 1'b0;
        penable = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        psel0   = 1'b0;
        psel3   = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        pstrb   = '0;
        repeat (3) @(negedge clk);
        check("rst_pready0",  32'(pready0),  32'h0);
        check("rst_pslverr0", 32'(pslverr0), 32'h0);
        check("rst_prdata0",  prdata0,       32'h0);
        check("rst_pready3",  32'(pready3),  32'h0);
        check("rst_prdata3",  prdata3,       32'h0);
        rst_n = 1'b1;

        // Zero-wait write then back-to-back read
        apb_xfer(0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0, "w0_10");
        apb_xfer(0, 1'b0, 12'h010, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0, "r0_10");

        // Byte-lane merge
        apb_xfer(0, 1'b1, 12'h008, 32'h11223344, 4'hF, 32'h0,        1'b0, "w0_08a");
        apb_xfer(0, 1'b1, 12'h008, 32'hAABBCCDD, 4'h5, 32'h0,        1'b0, "w0_08b");
        apb_xfer(0, 1'b0, 12'h008, 32'h0,        4'h0, 32'h11BB33DD, 1'b0, "r0_08");

        // Out-of-range and misaligned accesses leave storage untouched
        apb_xfer(0, 1'b1, 12'h100, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1, "w0_oob");
        apb_xfer(0, 1'b0, 12'h100, 32'h0,        4'hF, 32'h0,        1'b1, "r0_oob");
        apb_xfer(0, 1'b1, 12'h002, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1, "w0_mis");
        apb_xfer(0, 1'b0, 12'h002, 32'h0,        4'hF, 32'h0,        1'b1, "r0_mis");
        apb_xfer(0, 1'b0, 12'h000, 32'h0,        4'hF, 32'h0,        1'b0, "r0_00");

        // Access phase without a setup phase is ignored
        @(negedge clk);
        psel0   = 1'b1;
        psel3   = 1'b0;
        penable = 1'b1;
        pwrite  = 1'b1;
        paddr   = 12'h00C;
        pwdata  = 32'hBAD0BAD0;
        pstrb   = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("nosetup_pready", 32'(pready0), 32'h0);
        end
        apb_xfer(0, 1'b0, 12'h00C, 32'h0,        4'hF, 32'h0,        1'b0, "r0_0c");

        // Three wait states
        apb_xfer(3, 1'b0, 12'h004, 32'h0,        4'hF, 32'h0,        1'b0, "r3_04");
        apb_xfer(3, 1'b1, 12'h008, 32'h11223344, 4'hF, 32'h0,        1'b0, "w3_08a");
        apb_xfer(3, 1'b1, 12'h008, 32'hAABBCCDD, 4'h5, 32'h0,        1'b0, "w3_08b");
        apb_xfer(3, 1'b0, 12'h008, 32'h0,        4'h0, 32'h11BB33DD, 1'b0, "r3_08");
        apb_xfer(3, 1'b1, 12'h020, 32'h12345678, 4'hF, 32'h0,        1'b0, "w3_20");

        // PSEL dropped in the second access cycle aborts the write
        @(negedge clk);
        psel0   = 1'b0;
        psel3   = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 12'h020;
        pwdata  = 32'hCAFEF00D;
        pstrb   = 4'hF;
        @(negedge clk);
        penable = 1'b1;
        check("abort_acc1_pready", 32'(pready3), 32'h0);
        @(negedge clk);
        check("abort_acc2_pready", 32'(pready3), 32'h0);
        psel3   = 1'b0;
        penable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("abort_after_pready", 32'(pready3), 32'h0);
        end
        apb_xfer(3, 1'b0, 12'h020, 32'h0,        4'hF, 32'h12345678, 1'b0, "r3_20");

        // Reset pulsed in the middle of a wait-state write
        apb_xfer(3, 1'b1, 12'h028, 32'h55AA55AA, 4'hF, 32'h0,        1'b0, "w3_28");
        @(negedge clk);
        psel3   = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 12'h028;
        pwdata  = 32'h0F0F0F0F;
        pstrb   = 4'hF;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_pready3",  32'(pready3),  32'h0);
        check("rstmid_pslverr3", 32'(pslverr3), 32'h0);
        check("rstmid_prdata3",  prdata3,       32'h0);
        check("rstmid_prdata0",  prdata0,       32'h0);
        bus_idle();
        @(negedge clk);
        rst_n = 1'b1;
        apb_xfer(3, 1'b0, 12'h028, 32'h0,        4'hF, 32'h0,        1'b0, "r3_28_rst");
        apb_xfer(0, 1'b0, 12'h010, 32'h0,        4'hF, 32'h0,        1'b0, "r0_10_rst");
        bus_idle();

        check("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
